// File: rtl/rom_sequencer_if.sv
// Command bus between the ROM sequencer and the downstream consumer.
// The sequencer is the master: it offers bus_data_o under bus_valid_o and
// the consumer accepts it with bus_ready_i.
interface rom_sequencer_if #(
    parameter int OPW = 10
);
    logic           bus_valid_o;
    logic           bus_ready_i;
    logic [OPW-1:0] bus_data_o;

    modport master (
        output bus_valid_o,
        output bus_data_o,
        input  bus_ready_i
    );

    modport slave (
        input  bus_valid_o,
        input  bus_data_o,
        output bus_ready_i
    );
endinterface

// File: rtl/rom_sequencer.sv
// ROM-driven command sequencer. Fetches 3-bit-opcode instructions from a
// registered-read ROM and executes NOP / WR / WAIT / JMP / HALT. Every
// output is a register, updated on the same edge as the state transition,
// so each output always reflects the state it belongs to.
module rom_sequencer #(
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 13,
    localparam int OPW        = DATA_WIDTH - 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_rden_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    rom_sequencer_if.master       bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        WAIT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_WR   = 3'b001;
    localparam logic [2:0] OP_WAIT = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [OPW-1:0]        cnt;
    logic                  rden_q;
    logic                  valid_q;
    logic [OPW-1:0]        data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [2:0]            op;
    logic [OPW-1:0]        operand;

    assign op      = rom_data_i[DATA_WIDTH-1 -: 3];
    assign operand = rom_data_i[OPW-1:0];

    assign rom_addr_o      = pc;
    assign rom_rden_o      = rden_q;
    assign bus.bus_valid_o = valid_q;
    assign bus.bus_data_o  = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

    // Sequencer FSM: state, PC, wait counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            rden_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the end-of-program paths raise it
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        pc     <= start_addr_i;
                        err_q  <= 1'b0;
                        rden_q <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= FETCH;
                    end
                end

                FETCH: begin
                    // ROM read was issued this cycle; its data is valid in DECODE
                    rden_q <= 1'b0;
                    state  <= DECODE;
                end

                DECODE: begin
                    // JMP overrides this increment below; the width wraps naturally
                    pc <= pc + ADDR_WIDTH'(1);
                    unique case (op)
                        OP_NOP: begin
                            rden_q <= 1'b1;
                            state  <= FETCH;
                        end
                        OP_WR: begin
                            data_q  <= operand;
                            valid_q <= 1'b1;
                            state   <= WRITE;
                        end
                        OP_WAIT: begin
                            if (operand == '0) begin
                                rden_q <= 1'b1;
                                state  <= FETCH;
                            end else begin
                                cnt   <= operand;
                                state <= WAIT;
                            end
                        end
                        OP_JMP: begin
                            pc     <= operand[ADDR_WIDTH-1:0];
                            rden_q <= 1'b1;
                            state  <= FETCH;
                        end
                        OP_HALT: begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                        default: begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    endcase
                end

                WRITE: begin
                    // valid_q is high throughout WRITE, so ready alone completes the handshake
                    if (bus.bus_ready_i) begin
                        valid_q <= 1'b0;
                        rden_q  <= 1'b1;
                        state   <= FETCH;
                    end
                end

                WAIT: begin
                    cnt <= cnt - OPW'(1);
                    if (cnt == OPW'(1)) begin
                        rden_q <= 1'b1;
                        state  <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed programs in a behavioural ROM, a queue
// of expected fetch / bus-write / done events checked by a monitor, plus
// direct latency, busy and reset checks from the stimulus process.
module tb_rom_sequencer;

    localparam int AW  = 8;
    localparam int DW  = 13;
    localparam int OPW = DW - 3;

    localparam int EV_FETCH = 0;
    localparam int EV_BUS   = 1;
    localparam int EV_DONE  = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] rom_addr;
    logic          rom_rden;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] rom [256];

    rom_sequencer_if #(.OPW(OPW)) bus_if ();

    rom_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .start_addr_i (start_addr),
        .rom_addr_o   (rom_addr),
        .rom_rden_o   (rom_rden),
        .rom_data_i   (rom_data),
        .bus          (bus_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM model
    always @(posedge clk) begin
        if (rom_rden === 1'b1) rom_data <= rom[rom_addr];
    end

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [OPW-1:0] opd);
        return {op, opd};
    endfunction

    function automatic void expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic note(input int kind, input int val);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d value 0x%0h, expected no event", kind, val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL event: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every fetch, accepted bus write and done pulse is matched against the queue
    always @(negedge clk) begin
        if (rom_rden === 1'b1) note(EV_FETCH, 32'(rom_addr));
        if (bus_if.bus_valid_o === 1'b1 && bus_if.bus_ready_i === 1'b1)
            note(EV_BUS, 32'(bus_if.bus_data_o));
        if (done === 1'b1) note(EV_DONE, 32'(err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start a program and observe it until done or the cycle budget runs out.
    // lat is the number of edges from the start edge to the edge raising done (-1 on timeout).
    task automatic run(input logic [AW-1:0] addr, input int stall, input int max,
                       output int lat, output int busy_n, output int valid_n,
                       output int rden_n, output int data_chg, output int err1);
        int            stall_left;
        logic [OPW-1:0] first_data;
        logic           have_data;
        stall_left = stall;
        have_data  = 1'b0;
        first_data = '0;
        lat = -1; busy_n = 0; valid_n = 0; rden_n = 0; data_chg = 0; err1 = 0;
        start_addr = addr;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= max; k++) begin
            if (k == 1) err1 = 32'(err);
            busy_n  += 32'(busy);
            rden_n  += 32'(rom_rden);
            valid_n += 32'(bus_if.bus_valid_o);
            if (bus_if.bus_valid_o) begin
                if (!have_data) begin
                    first_data = bus_if.bus_data_o;
                    have_data  = 1'b1;
                end else if (bus_if.bus_data_o != first_data) begin
                    data_chg++;
                end
            end
            if (done) begin
                lat = k - 1;
                break;
            end
            if (k == max) break;
            if (bus_if.bus_valid_o && stall_left > 0) begin
                bus_if.bus_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus_if.bus_ready_i = 1'b1;
            end
            tick();
        end
        bus_if.bus_ready_i = 1'b1;
    endtask

    int lat, busy_n, valid_n, rden_n, data_chg, err1;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom_data           = '0;
        rst                = 1'b1;
        start              = 1'b0;
        start_addr         = '0;
        bus_if.bus_ready_i = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_busy",     32'(busy), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_err",      32'(err), 0);
        chk("rst_rden",     32'(rom_rden), 0);
        chk("rst_valid",    32'(bus_if.bus_valid_o), 0);
        chk("rst_bus_data", 32'(bus_if.bus_data_o), 0);
        chk("rst_addr",     32'(rom_addr), 0);
        rst = 1'b0;
        tick();

        // WR 0x055 then HALT, ready always high
        rom[8'h10] = ins(3'b001, 10'h055);
        rom[8'h11] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'h10);
        expect_ev(EV_BUS,   'h055);
        expect_ev(EV_FETCH, 'h11);
        expect_ev(EV_DONE,  0);
        run(8'h10, 0, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("wr_latency", lat, 5);
        chk("wr_busy",    busy_n, 5);
        chk("wr_valid",   valid_n, 1);
        chk("wr_err",     32'(err), 0);
        tick();
        chk("wr_done_pulse", 32'(done), 0);

        // Same program, ready held low for 4 cycles
        expect_ev(EV_FETCH, 'h10);
        expect_ev(EV_BUS,   'h055);
        expect_ev(EV_FETCH, 'h11);
        expect_ev(EV_DONE,  0);
        run(8'h10, 4, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("stall_valid",   valid_n, 5);
        chk("stall_stable",  data_chg, 0);
        chk("stall_latency", lat, 9);
        tick();

        // WAIT 3 then HALT
        rom[8'h00] = ins(3'b010, 10'd3);
        rom[8'h01] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'h00);
        expect_ev(EV_FETCH, 'h01);
        expect_ev(EV_DONE,  0);
        run(8'h00, 0, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("wait_latency", lat, 7);
        chk("wait_rden",    rden_n, 2);
        chk("wait_busy",    busy_n, 7);
        tick();

        // PC wrap from 0xFF, then JMP 0x20 to HALT
        rom[8'hFF] = ins(3'b000, 10'h000);
        rom[8'h00] = ins(3'b011, 10'h020);
        rom[8'h20] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'hFF);
        expect_ev(EV_FETCH, 'h00);
        expect_ev(EV_FETCH, 'h20);
        expect_ev(EV_DONE,  0);
        run(8'hFF, 0, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("jmp_latency", lat, 6);
        chk("jmp_rden",    rden_n, 3);
        tick();

        // NOP, WAIT 0, WR 0x3FF with 2 stall cycles, HALT
        rom[8'h40] = ins(3'b000, 10'h000);
        rom[8'h41] = ins(3'b010, 10'h000);
        rom[8'h42] = ins(3'b001, 10'h3FF);
        rom[8'h43] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'h40);
        expect_ev(EV_FETCH, 'h41);
        expect_ev(EV_FETCH, 'h42);
        expect_ev(EV_BUS,   'h3FF);
        expect_ev(EV_FETCH, 'h43);
        expect_ev(EV_DONE,  0);
        run(8'h40, 2, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("mix_latency", lat, 11);
        chk("mix_valid",   valid_n, 3);
        chk("mix_busy",    busy_n, 11);
        tick();

        // Reserved opcode 110: error and done, err sticky until the next start
        rom[8'h00] = ins(3'b110, 10'h000);
        expect_ev(EV_FETCH, 'h00);
        expect_ev(EV_DONE,  1);
        run(8'h00, 0, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("rsv_latency", lat, 2);
        chk("rsv_err",     32'(err), 1);
        tick();
        tick();
        chk("rsv_err_sticky", 32'(err), 1);
        rom[8'h30] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'h30);
        expect_ev(EV_DONE,  0);
        run(8'h30, 0, 40, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("restart_err_cleared", err1, 0);
        chk("restart_latency",     lat, 2);
        tick();

        // JMP to itself spins until reset; 20 observed cycles hold 10 fetches
        rom[8'h50] = ins(3'b011, 10'h050);
        for (int i = 0; i < 10; i++) expect_ev(EV_FETCH, 'h50);
        run(8'h50, 0, 20, lat, busy_n, valid_n, rden_n, data_chg, err1);
        chk("loop_no_done", lat, -1);
        chk("loop_busy",    32'(busy), 1);
        chk("loop_err",     32'(err), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("loop_rst_busy", 32'(busy), 0);
        chk("loop_rst_pc",   32'(rom_addr), 0);
        tick();

        // Reset in the middle of a stalled WRITE, with start in the reset cycle
        rom[8'h60] = ins(3'b001, 10'h123);
        rom[8'h61] = ins(3'b100, 10'h000);
        expect_ev(EV_FETCH, 'h60);
        bus_if.bus_ready_i = 1'b0;
        start_addr = 8'h60;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midwr_valid", 32'(bus_if.bus_valid_o), 1);
        chk("midwr_data",  32'(bus_if.bus_data_o), 'h123);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("midwr_rst_valid", 32'(bus_if.bus_valid_o), 0);
        chk("midwr_rst_busy",  32'(busy), 0);
        chk("midwr_rst_data",  32'(bus_if.bus_data_o), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("midwr_start_ignored", 32'(busy), 0);
        chk("midwr_no_fetch",      32'(rom_rden), 0);
        bus_if.bus_ready_i = 1'b1;
        tick();
        tick();

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: ROM address width and program-counter width.
REQ-002 SHALL have parameter DATA_WIDTH, default 13: ROM word width, with DATA_WIDTH >= ADDR_WIDTH+3 and operand width OPW = DATA_WIDTH-3.
REQ-003 SHALL have clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have start_i, input, 1: start program execution, sampled in IDLE only.
REQ-006 SHALL have start_addr_i, input, ADDR_WIDTH: first instruction address, captured with start_i.
REQ-007 SHALL have rom_addr_o, output, ADDR_WIDTH: ROM address, equal to the PC.
REQ-008 SHALL have rom_rden_o, output, 1: ROM read enable.
REQ-009 SHALL have rom_data_i, input, DATA_WIDTH: ROM registered read data, valid the cycle after rom_rden_o.
REQ-010 SHALL have bus_valid_o, output, 1: bus command valid.
REQ-011 SHALL have bus_ready_i, input, 1: bus command accepted.
REQ-012 SHALL have bus_data_o, output, OPW: bus command payload.
REQ-013 SHALL have busy_o, output, 1: high in every state except IDLE.
REQ-014 SHALL have done_o, output, 1: one-cycle pulse on program end.
REQ-015 SHALL have err_o, output, 1: sticky flag, reserved opcode executed.

Function
REQ-016 Instruction format SHALL be op = word[DATA_WIDTH-1 -: 3] and operand = word[OPW-1:0].
REQ-017 Opcodes SHALL be:
- 000 NOP
- 001 WR (issue operand on bus)
- 010 WAIT (stall operand cycles)
- 011 JMP (PC <= operand[ADDR_WIDTH-1:0])
- 100 HALT
- 101..111 reserved
REQ-018 FSM states SHALL be IDLE, FETCH, DECODE, WRITE, WAIT.
REQ-019 IDLE with start_i=1 SHALL load PC <= start_addr_i, clear err_o, and go to FETCH; start_i SHALL be ignored in all other states.
REQ-020 FETCH SHALL drive rom_rden_o=1 and rom_addr_o=PC for exactly one cycle, then go to DECODE; rom_rden_o SHALL be 0 in all other states.
REQ-021 DECODE SHALL sample rom_data_i and set PC <= PC+1, wrapping from 2**ADDR_WIDTH-1 to 0, for every opcode except JMP.
REQ-022 DECODE transitions by opcode SHALL be:
- NOP: go to FETCH
- WR: latch operand into bus_data_o, go to WRITE
- WAIT with operand=0: go to FETCH
- WAIT with operand>0: load counter with operand, go to WAIT
- JMP: go to FETCH
- HALT: pulse done_o, go to IDLE
- reserved: set err_o, pulse done_o, go to IDLE
REQ-023 WRITE SHALL hold bus_valid_o=1 with bus_data_o stable until bus_valid_o & bus_ready_i; on that cycle it SHALL go to FETCH, and bus_valid_o SHALL deassert the following cycle.
REQ-024 bus_ready_i SHALL be ignored outside WRITE, and bus_valid_o SHALL be 0 outside WRITE.
REQ-025 WAIT SHALL decrement the counter each cycle and go to FETCH on the cycle the counter is 1, giving exactly operand cycles in WAIT.
REQ-026 Latency per instruction SHALL be:
- NOP, JMP, WAIT 0: 2 cycles
- WAIT N: 2+N cycles
- WR: 3 cycles plus ready stall cycles
REQ-027 A JMP to its own address SHALL loop indefinitely without error; only reset stops it.
REQ-028 err_o SHALL remain set until the next accepted start_i or reset.

Reset
REQ-029 rst_i=1 SHALL, on the next edge and from any state (including mid-WRITE or mid-WAIT), force:
- state IDLE
- PC=0, counter=0
- rom_rden_o=0, bus_valid_o=0, bus_data_o=0
- busy_o=0, done_o=0, err_o=0
REQ-030 A start_i asserted in the same cycle as rst_i SHALL be ignored.

Verification
REQ-031 ROM[0x10]=WR 0x055, ROM[0x11]=HALT, bus_ready_i=1, start_addr_i=0x10 -> one bus_valid_o cycle with bus_data_o=0x055, then done_o pulse; busy_o high for 5 cycles.
REQ-032 Same program with bus_ready_i low for 4 cycles -> bus_valid_o high 5 cycles, bus_data_o stable at 0x055 throughout.
REQ-033 ROM[0]=WAIT 3, ROM[1]=HALT -> done_o exactly 7 cycles after start_i, with no rom_rden_o during WAIT.
REQ-034 ROM[0xFF]=NOP, ROM[0]=JMP 0x20, ROM[0x20]=HALT, start_addr_i=0xFF -> PC wraps to 0, the jump is taken, and the fetch sequence is 0xFF, 0x00, 0x20.
REQ-035 ROM[0]=opcode 110 -> err_o=1 and a done_o pulse; a subsequent start_i clears err_o.
REQ-036 rst_i asserted during WRITE with bus_ready_i=0 -> next cycle bus_valid_o=0, busy_o=0, and a start_i in that reset cycle is ignored.
